// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The memory answers in the same cycle it asserts imem_ready.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives imem, and fills IF/ID.
// A one-entry hold buffer keeps a response that lands while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_stall,
  input  logic               flush_fe,
  input  logic               taken,
  input  logic [31:0]        branch_target,
  fetch_stage_if.master      imem,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_instr
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  logic        req;
  logic        done;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // A full hold buffer means decode cannot take another word yet, so don't ask.
  assign req      = !rst && ((state_q == DRAIN) || !hold_valid_q);
  assign done     = req && imem.imem_ready;
  assign target   = branch_target & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    hold_valid_d  = hold_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;

    if (taken) begin
      if_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      if (state_q == DRAIN) begin
        if (imem.imem_ready) begin
          pc_d    = target;
          state_d = FETCH;
        end else begin
          redirect_pc_d = target;
        end
      end else if (imem.imem_ready || !req) begin
        pc_d = target;
      end else begin
        // Request can't be withdrawn: park the target until the old one completes.
        redirect_pc_d = target;
        state_d       = DRAIN;
      end
    end else if (state_q == DRAIN) begin
      if_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      if (imem.imem_ready) begin
        pc_d    = redirect_pc_q;
        state_d = FETCH;
      end
    end else if (flush_fe) begin
      if_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
    end else if (pc_stall) begin
      if (done && !hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = pc_q;
        hold_instr_d = imem.imem_rdata;
        pc_d         = pc_plus4;
      end
    end else if (hold_valid_q) begin
      if_valid_d   = 1'b1;
      if_pc_d      = hold_pc_q;
      if_instr_d   = hold_instr_q;
      hold_valid_d = 1'b0;
    end else if (done) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_instr_d = imem.imem_rdata;
      pc_d       = pc_plus4;
    end else begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_instr_q    <= NOP;
      hold_valid_q  <= 1'b0;
      hold_pc_q     <= 32'h0;
      hold_instr_q  <= NOP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      hold_valid_q  <= hold_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns {addr[15:0], 16'h0013} for each address.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_stall;
  logic        flush_fe;
  logic        taken;
  logic [31:0] branch_target;
  logic        ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_stage_if bus ();

  assign bus.imem_ready = ready;
  assign bus.imem_rdata = {bus.imem_addr[15:0], 16'h0013};

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_stall      (pc_stall),
    .flush_fe      (flush_fe),
    .taken         (taken),
    .branch_target (branch_target),
    .imem          (bus),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_stall = 1'b0; flush_fe = 1'b0; taken = 1'b0;
    branch_target = 32'h0; ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0000_0013);
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);

    rst = 1'b0; #1;
    check("c0_req", {31'h0, bus.imem_req}, 32'h1);
    check("c0_addr", bus.imem_addr, 32'h100);
    tick();
    check("c1_addr", bus.imem_addr, 32'h104);
    check("c1_valid", {31'h0, if_valid}, 32'h1);
    check("c1_pc", if_pc, 32'h100);
    check("c1_instr", if_instr, 32'h0100_0013);

    // memory not ready for three cycles at 0x104
    ready = 1'b0;
    tick();
    check("wait1_addr", bus.imem_addr, 32'h104);
    check("wait1_valid", {31'h0, if_valid}, 32'h0);
    tick();
    check("wait2_valid", {31'h0, if_valid}, 32'h0);
    tick();
    check("wait3_valid", {31'h0, if_valid}, 32'h0);
    check("wait3_addr", bus.imem_addr, 32'h104);
    ready = 1'b1;
    tick();
    check("c5_pc", if_pc, 32'h104);
    check("c5_instr", if_instr, 32'h0104_0013);
    check("c5_addr", bus.imem_addr, 32'h108);

    // two-cycle stall: 0x108 lands in the hold buffer
    pc_stall = 1'b1;
    tick();
    check("stall2_pc", if_pc, 32'h104);
    check("stall2_valid", {31'h0, if_valid}, 32'h1);
    check("stall2_req", {31'h0, bus.imem_req}, 32'h0);
    tick();
    pc_stall = 1'b0;
    check("rel_pc", if_pc, 32'h104);
    check("rel_req", {31'h0, bus.imem_req}, 32'h0);
    tick();
    check("held_pc", if_pc, 32'h108);
    check("held_instr", if_instr, 32'h0108_0013);
    check("held_req", {31'h0, bus.imem_req}, 32'h1);
    check("held_addr", bus.imem_addr, 32'h10C);
    tick();
    check("c9_pc", if_pc, 32'h10C);
    check("c9_addr", bus.imem_addr, 32'h110);

    // branch while the request at 0x110 stays pending
    ready = 1'b0; taken = 1'b1; branch_target = 32'h200;
    tick();
    taken = 1'b0;
    check("drain1_addr", bus.imem_addr, 32'h110);
    check("drain1_req", {31'h0, bus.imem_req}, 32'h1);
    check("drain1_valid", {31'h0, if_valid}, 32'h0);
    tick();
    check("drain2_addr", bus.imem_addr, 32'h110);
    ready = 1'b1;
    tick();
    check("redir_addr", bus.imem_addr, 32'h200);
    check("redir_valid", {31'h0, if_valid}, 32'h0);
    tick();
    check("tgt_pc", if_pc, 32'h200);
    check("tgt_instr", if_instr, 32'h0200_0013);

    // taken with ready in the same cycle; low target bits ignored
    taken = 1'b1; branch_target = 32'h3;
    tick();
    taken = 1'b0;
    check("t3_addr", bus.imem_addr, 32'h0);
    check("t3_valid", {31'h0, if_valid}, 32'h0);
    tick();
    check("t3_pc", if_pc, 32'h0);
    check("t3_valid2", {31'h0, if_valid}, 32'h1);
    check("t3_next", bus.imem_addr, 32'h4);

    // PC wrap
    taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    taken = 1'b0;
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", bus.imem_addr, 32'h0);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_instr", if_instr, 32'hFFFC_0013);

    // newer redirect wins when it coincides with drain completion
    ready = 1'b0; taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_target = 32'h400; ready = 1'b1;
    tick();
    taken = 1'b0;
    check("newer_addr", bus.imem_addr, 32'h400);
    check("newer_valid", {31'h0, if_valid}, 32'h0);

    // reset during a stall with a captured word
    pc_stall = 1'b1;
    tick();
    check("pre_rst_req", {31'h0, bus.imem_req}, 32'h0);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    check("mid_rst_pc", if_pc, 32'h0);
    check("mid_rst_instr", if_instr, 32'h0000_0013);
    check("mid_rst_req", {31'h0, bus.imem_req}, 32'h0);
    rst = 1'b0; pc_stall = 1'b0; #1;
    check("post_rst_addr", bus.imem_addr, 32'h100);
    check("post_rst_req", {31'h0, bus.imem_req}, 32'h1);
    tick();
    check("post_rst_pc", if_pc, 32'h100);
    check("post_rst_valid", {31'h0, if_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
